vga_pixel_feeder: RTL and testbench
===================================

// Module: vga_pixel_feeder
// PURPOSE
//  Single-clock pixel buffer/sequencer upstream of the VGA timing generator.
//  Accepts a 24-bit RGB pixel stream (valid/ready, start-of-frame marker).
//  Buffers it in an internal synchronous FIFO and delivers one pixel per
//  active-display slot requested by the timing generator.
//  Locks the stream to the raster, and detects underflow and frame desync
//  with automatic resync.
// PARAMETERS
//  HDISP       800        active pixels per line
//  VDISP       480        active lines per frame
//  DEPTH       256        FIFO depth in words, power of 2, >=4
//  FILL_LEVEL  128        min FIFO level before RUN may start, 1..DEPTH
//  ERR_RGB     24'hFF0000 colour output during underflow
// PORTS
//  pixel_clk    in   1   pixel clock, all logic on rising edge
//  pixel_rst_n  in   1   reset, asynchronous assert, active-low
//  s_data       in   24  input pixel RGB
//  s_sof        in   1   s_data is pixel (0,0) of a frame
//  s_valid      in   1   input word valid
//  s_ready      out  1   input word accepted when s_valid & s_ready
//  frame_start  in   1   1-cycle pulse from timing gen, start of vertical blank
//  display_en   in   1   timing gen consumes one pixel this cycle (active area)
//  rgb          out  24  output pixel, registered
//  running      out  1   state == RUN
//  underflow    out  1   1-cycle pulse: display_en while FIFO empty in RUN
//  desync       out  1   1-cycle pulse: sof/pixel-count mismatch
//  level        out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: rgb=0, s_ready=0, running=0, underflow=0, desync=0, level=0.
//  Reset also clears FIFO pointers, pix_cnt=0, state=SYNC. Reset mid-frame
//  discards all buffered data.
//  FIFO entry = {sof,data}, 25 bits.
//  Push when s_valid & s_ready. s_ready = !full in FILL/RUN; 1 in SYNC.
//  Pop allowed when !empty. Push and pop in the same cycle are both legal;
//  level is unchanged. s_ready does not depend on the same-cycle pop.
//  FSM:
//   SYNC: drop words with s_sof=0. A word with s_sof=1 is written -> FILL.
//   FILL: push only, no pop. At frame_start with level>=FILL_LEVEL -> RUN,
//         pix_cnt=0. frame_start with level<FILL_LEVEL: stay in FILL.
//   RUN:  on display_en pop the head word. rgb<=data on the next edge
//         (latency 1). pix_cnt increments and wraps at HDISP*VDISP-1 -> 0.
//  Output when no pop:
//   - display_en=0: rgb<=0 next cycle, whatever the state.
//   - display_en=1 outside RUN: rgb<=0.
//  Errors in RUN (each one: pulse flag, flush FIFO in one cycle, pix_cnt=0,
//  -> SYNC; any word pushed in the same cycle is lost):
//   - underflow: display_en & empty -> rgb<=ERR_RGB, underflow=1.
//   - desync: popped sof != (pix_cnt==0) -> rgb<=popped data, desync=1.
//   - desync: frame_start while pix_cnt!=0 (short frame) -> desync=1.
//  Underflow and desync in the same cycle cannot occur (no pop on empty).
//  pix_cnt width = $clog2(HDISP*VDISP).
// CONFIGURATION
//  VGA_FEEDER_UNDERFLOW_CNT_EN defined:
//   - adds output port underflow_cnt [15:0].
//   - counts underflow pulses, saturates at 16'hFFFF, reset to 0.
//   - cleared only by reset.
//  Not defined: port absent, no counter logic. All other behaviour identical.
// TESTING
//  1 Reset: hold pixel_rst_n=0 with s_valid=1 -> s_ready=0, rgb=0, level=0,
//    running=0.
//  2 Lock: send 5 non-sof words then a sof frame (HDISP=8, VDISP=2, 16 px,
//    values 1..16) -> first 5 dropped; RUN after frame_start once level>=FILL.
//    First display_en -> rgb=24'h000001 one cycle later.
//  3 Steady state: 3 frames streamed at full rate -> rgb equals the input
//    sequence exactly, no underflow/desync, pix_cnt wraps 15->0.
//  4 Underflow: stop input mid-frame until FIFO empty -> next display_en
//    gives rgb=ERR_RGB, underflow pulse, level=0, state SYNC. Resumes at the
//    next sof.
//  5 Desync: inject s_sof=1 on pixel 9 -> desync pulse on its pop, FIFO
//    flushed, relock on the following sof.
//  6 Full/simultaneous: fill to DEPTH -> s_ready=0. Push+pop in the same
//    cycle -> level holds. With the macro, 3 underflows -> underflow_cnt=3.

Source files
------------

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder
//   Pixel buffer and sequencer that sits upstream of the VGA timing generator.
//   It takes a 24-bit RGB stream (valid/ready plus a start-of-frame flag) and
//   stores it in an internal single-clock FIFO. It then returns one pixel for
//   each active-display slot the timing generator asks for.
//   It locks the stream to the raster. Underflow and frame desync each flush
//   the buffer and make it wait for the next start-of-frame word.
//   Optional feature macro: VGA_FEEDER_UNDERFLOW_CNT_EN adds a saturating
//   16-bit underflow event counter on port underflow_cnt.
module vga_pixel_feeder #(
   parameter int          HDISP      = 800,
   parameter int          VDISP      = 480,
   parameter int          DEPTH      = 256,
   parameter int          FILL_LEVEL = 128,
   parameter logic [23:0] ERR_RGB    = 24'hFF0000
) (
   input  logic                     pixel_clk,
   input  logic                     pixel_rst_n,
   input  logic [23:0]              s_data,
   input  logic                     s_sof,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     frame_start,
   input  logic                     display_en,
   output logic [23:0]              rgb,
   output logic                     running,
   output logic                     underflow,
   output logic                     desync,
   output logic [$clog2(DEPTH):0]   level
`ifdef VGA_FEEDER_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]              underflow_cnt
`endif
);

   localparam int             AW       = $clog2(DEPTH);
   localparam int             NPIX     = HDISP * VDISP;
   localparam int             PCW      = $clog2(NPIX);
   localparam logic [PCW-1:0] PIX_LAST = PCW'(NPIX - 1);
   localparam logic [AW:0]    DEPTH_LV = (AW + 1)'(DEPTH);
   localparam logic [AW:0]    FILL_LV  = (AW + 1)'(FILL_LEVEL);

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [24:0]     mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW:0]     count_r;
   logic [AW:0]     count_nxt_s;
   logic [PCW-1:0]  pix_cnt_r;
   logic [PCW-1:0]  pix_cnt_nxt_s;
   logic [23:0]     rgb_r;
   logic [23:0]     rgb_nxt_s;
   logic            s_ready_r;
   logic            underflow_r;
   logic            desync_r;
   logic            push_s;
   logic            pop_s;
   logic            flush_s;
   logic            underflow_s;
   logic            desync_s;
   logic            empty_s;
   logic            pix_first_s;
   logic            short_frame_s;
   logic [24:0]     head_s;

   assign empty_s       = (count_r == {(AW + 1){1'b0}});
   assign head_s        = mem_r[rd_ptr_r];
   assign pix_first_s   = (pix_cnt_r == {PCW{1'b0}});
   assign short_frame_s = frame_start && !pix_first_s;

   // Next-state, FIFO control and output selection for the lock/run sequencer
   always_comb begin
      state_nxt_s   = state_r;
      pix_cnt_nxt_s = pix_cnt_r;
      rgb_nxt_s     = 24'h000000;
      push_s        = 1'b0;
      pop_s         = 1'b0;
      flush_s       = 1'b0;
      underflow_s   = 1'b0;
      desync_s      = 1'b0;
      case (state_r)
         SYNC: begin
            // Words without a frame marker are accepted and dropped.
            if (s_valid && s_ready_r && s_sof) begin
               push_s      = 1'b1;
               state_nxt_s = FILL;
            end else begin
               push_s      = 1'b0;
            end
         end
         FILL: begin
            push_s = s_valid && s_ready_r;
            if (frame_start && (count_r >= FILL_LV)) begin
               state_nxt_s   = RUN;
               pix_cnt_nxt_s = {PCW{1'b0}};
            end else begin
               state_nxt_s   = FILL;
            end
         end
         RUN: begin
            push_s = s_valid && s_ready_r;
            if (display_en && empty_s) begin
               underflow_s = 1'b1;
               rgb_nxt_s   = ERR_RGB;
            end else if (display_en) begin
               pop_s     = 1'b1;
               rgb_nxt_s = head_s[23:0];
               if (pix_cnt_r == PIX_LAST) begin
                  pix_cnt_nxt_s = {PCW{1'b0}};
               end else begin
                  pix_cnt_nxt_s = pix_cnt_r + PCW'(1);
               end
               if (head_s[24] != pix_first_s) begin
                  desync_s = 1'b1;
               end else begin
                  desync_s = short_frame_s;
               end
            end else begin
               desync_s = short_frame_s;
            end
            // Any error drops the buffer (including a same-cycle push) and relocks.
            if (underflow_s || desync_s) begin
               flush_s       = 1'b1;
               push_s        = 1'b0;
               pix_cnt_nxt_s = {PCW{1'b0}};
               state_nxt_s   = SYNC;
            end else begin
               state_nxt_s   = RUN;
            end
         end
         default: begin
            flush_s       = 1'b1;
            pix_cnt_nxt_s = {PCW{1'b0}};
            state_nxt_s   = SYNC;
         end
      endcase
   end

   // FIFO occupancy after this cycle's push/pop/flush
   always_comb begin
      if (flush_s) begin
         count_nxt_s = {(AW + 1){1'b0}};
      end else if (push_s && !pop_s) begin
         count_nxt_s = count_r + (AW + 1)'(1);
      end else if (!push_s && pop_s) begin
         count_nxt_s = count_r - (AW + 1)'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge pixel_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {s_sof, s_data};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW + 1){1'b0}};
      end else if (flush_s) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW + 1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_nxt_s;
      end
   end

   // Sequencer state, pixel counter and registered outputs
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         state_r     <= SYNC;
         pix_cnt_r   <= {PCW{1'b0}};
         rgb_r       <= 24'h000000;
         s_ready_r   <= 1'b0;
         underflow_r <= 1'b0;
         desync_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pix_cnt_r   <= pix_cnt_nxt_s;
         rgb_r       <= rgb_nxt_s;
         // Ready is taken from the registered level, so it never depends on a same-cycle pop.
         s_ready_r   <= (state_nxt_s == SYNC) ? 1'b1 : (count_nxt_s != DEPTH_LV);
         underflow_r <= underflow_s;
         desync_r    <= desync_s;
      end
   end

`ifdef VGA_FEEDER_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt_r;

   // Saturating count of underflow events, cleared only by reset
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         underflow_cnt_r <= 16'h0000;
      end else if (underflow_s && (underflow_cnt_r != 16'hFFFF)) begin
         underflow_cnt_r <= underflow_cnt_r + 16'h0001;
      end else begin
         underflow_cnt_r <= underflow_cnt_r;
      end
   end

   assign underflow_cnt = underflow_cnt_r;
`endif

   assign s_ready   = s_ready_r;
   assign rgb       = rgb_r;
   assign running   = (state_r == RUN);
   assign underflow = underflow_r;
   assign desync    = desync_r;
   assign level     = count_r;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb_vga_pixel_feeder
//   Directed bench for vga_pixel_feeder with an 8x2 raster, a 32-word FIFO
//   and a fill threshold of 8.
module tb_vga_pixel_feeder;

   localparam int          HD  = 8;
   localparam int          VD  = 2;
   localparam int          DP  = 32;
   localparam int          FL  = 8;
   localparam logic [23:0] ERR = 24'hFF0000;

   logic        pixel_clk = 1'b0;
   logic        pixel_rst_n = 1'b0;
   logic [23:0] s_data = 24'h000000;
   logic        s_sof = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        frame_start = 1'b0;
   logic        display_en = 1'b0;
   logic [23:0] rgb;
   logic        running;
   logic        underflow;
   logic        desync;
   logic [5:0]  level;
`ifdef VGA_FEEDER_UNDERFLOW_CNT_EN
   logic [15:0] underflow_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   vga_pixel_feeder #(
      .HDISP(HD), .VDISP(VD), .DEPTH(DP), .FILL_LEVEL(FL), .ERR_RGB(ERR)
   ) dut (
      .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
      .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
      .frame_start(frame_start), .display_en(display_en),
      .rgb(rgb), .running(running), .underflow(underflow), .desync(desync),
      .level(level)
`ifdef VGA_FEEDER_UNDERFLOW_CNT_EN
      , .underflow_cnt(underflow_cnt)
`endif
   );

   always #5 pixel_clk = ~pixel_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic push_words(input logic [23:0] base, input int n, input int sof_a, input int sof_b);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = base + 24'(i);
         s_sof   = (i == sof_a) || (i == sof_b);
         tick();
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      pixel_rst_n = 1'b0;
      s_valid = 1'b1; s_sof = 1'b1; s_data = 24'h123456;
      repeat (3) tick();
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      n_checks++; if (rgb !== 24'h000000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000000", rgb); end
      n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      n_checks++; if ({running, underflow, desync} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {running, underflow, desync}); end
      s_valid = 1'b0; s_sof = 1'b0; s_data = 24'h000000;
      pixel_rst_n = 1'b1;
      tick();
      n_checks++; if ({s_ready, running} !== 2'b10) begin n_fail++; $display("FAIL sync_ready: got %b want 10", {s_ready, running}); end
   endtask

   task automatic test_lock();
      push_words(24'h0000A0, 5, -1, -1);
      n_checks++; if ({level, running} !== {6'd0, 1'b0}) begin n_fail++; $display("FAIL lock_drop: level %0d running %b want 0 0", level, running); end
      push_words(24'h000001, 16, 0, -1);
      n_checks++; if ({level, running} !== {6'd16, 1'b0}) begin n_fail++; $display("FAIL lock_fill: level %0d running %b want 16 0", level, running); end
      pulse_fs();
      n_checks++; if ({level, running} !== {6'd16, 1'b1}) begin n_fail++; $display("FAIL lock_run: level %0d running %b want 16 1", level, running); end
      display_en = 1'b1;
      tick();
      display_en = 1'b0;
      n_checks++; if (rgb !== 24'h000001) begin n_fail++; $display("FAIL lock_first_px: got %h want 000001", rgb); end
      n_checks++; if (level !== 6'd15) begin n_fail++; $display("FAIL lock_level: got %0d want 15", level); end
   endtask

   task automatic test_steady();
      int   nv;
      logic pushing;
      nv = 17;
      for (int f = 0; f < 3; f++) begin
         for (int p = (f == 0) ? 1 : 0; p < 16; p++) begin
            display_en = 1'b1;
            pushing    = (nv <= 48);
            s_valid    = pushing;
            s_data     = 24'(nv);
            s_sof      = pushing && (((nv - 1) % 16) == 0);
            tick();
            if (pushing) nv++;
            n_checks++;
            if ({rgb, underflow, desync} !== {24'(16 * f + p + 1), 2'b00}) begin
               n_fail++; $display("FAIL steady_px f%0d p%0d: got %h/%b%b want %h/00", f, p, rgb, underflow, desync, 24'(16 * f + p + 1));
            end
            if (pushing) begin
               n_checks++; if (level !== 6'd15) begin n_fail++; $display("FAIL steady_level f%0d p%0d: got %0d want 15", f, p, level); end
            end
         end
         display_en = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
         pulse_fs();
         n_checks++; if ({rgb, running, desync} !== {24'h000000, 2'b10}) begin n_fail++; $display("FAIL steady_vblank f%0d: got %h/%b%b want 000000/10", f, rgb, running, desync); end
      end
      n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL steady_drain: got %0d want 0", level); end
   endtask

   task automatic test_underflow();
      push_words(24'h000100, 5, 0, -1);
      n_checks++; if (level !== 6'd5) begin n_fail++; $display("FAIL uf_level: got %0d want 5", level); end
      for (int p = 0; p < 5; p++) begin
         display_en = 1'b1;
         tick();
         n_checks++; if (rgb !== 24'h000100 + 24'(p)) begin n_fail++; $display("FAIL uf_px%0d: got %h want %h", p, rgb, 24'h000100 + 24'(p)); end
      end
      tick();
      display_en = 1'b0;
      n_checks++; if ({rgb, underflow, level, running} !== {ERR, 1'b1, 6'd0, 1'b0}) begin n_fail++; $display("FAIL uf_event: got %h/%b/%0d/%b want %h/1/0/0", rgb, underflow, level, running, ERR); end
      tick();
      n_checks++; if ({rgb, underflow} !== {24'h000000, 1'b0}) begin n_fail++; $display("FAIL uf_pulse_end: got %h/%b want 000000/0", rgb, underflow); end
      push_words(24'h0001F0, 2, -1, -1);
      n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL uf_drop: got %0d want 0", level); end
      push_words(24'h000200, 16, 0, -1);
      pulse_fs();
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL uf_relock: got %b want 1", running); end
      for (int p = 0; p < 16; p++) begin
         display_en = 1'b1;
         tick();
         n_checks++; if ({rgb, underflow, desync} !== {24'h000200 + 24'(p), 2'b00}) begin n_fail++; $display("FAIL uf_resume_px%0d: got %h/%b%b want %h/00", p, rgb, underflow, desync, 24'h000200 + 24'(p)); end
      end
      display_en = 1'b0;
   endtask

   task automatic test_desync();
      push_words(24'h000300, 16, 0, 9);
      for (int p = 0; p < 9; p++) begin
         display_en = 1'b1;
         tick();
         n_checks++; if ({rgb, desync} !== {24'h000300 + 24'(p), 1'b0}) begin n_fail++; $display("FAIL ds_px%0d: got %h/%b want %h/0", p, rgb, desync, 24'h000300 + 24'(p)); end
      end
      tick();
      display_en = 1'b0;
      n_checks++; if ({rgb, desync, level, running} !== {24'h000309, 1'b1, 6'd0, 1'b0}) begin n_fail++; $display("FAIL ds_event: got %h/%b/%0d/%b want 000309/1/0/0", rgb, desync, level, running); end
      tick();
      n_checks++; if (desync !== 1'b0) begin n_fail++; $display("FAIL ds_pulse_end: got %b want 0", desync); end
      push_words(24'h0003F0, 3, -1, -1);
      n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL ds_drop: got %0d want 0", level); end
      push_words(24'h000400, 4, 0, -1);
      pulse_fs();
      n_checks++; if ({running, level} !== {1'b0, 6'd4}) begin n_fail++; $display("FAIL ds_below_fill: got %b/%0d want 0/4", running, level); end
      push_words(24'h000404, 4, -1, -1);
      pulse_fs();
      n_checks++; if ({running, level} !== {1'b1, 6'd8}) begin n_fail++; $display("FAIL ds_at_fill: got %b/%0d want 1/8", running, level); end
      push_words(24'h000408, 8, -1, -1);
      for (int p = 0; p < 16; p++) begin
         display_en = 1'b1;
         tick();
         n_checks++; if ({rgb, desync} !== {24'h000400 + 24'(p), 1'b0}) begin n_fail++; $display("FAIL ds_relock_px%0d: got %h/%b want %h/0", p, rgb, desync, 24'h000400 + 24'(p)); end
      end
      display_en = 1'b0;
      push_words(24'h000450, 8, 0, -1);
      for (int p = 0; p < 5; p++) begin
         display_en = 1'b1;
         tick();
      end
      display_en = 1'b0;
      pulse_fs();
      n_checks++; if ({desync, running, level} !== {1'b1, 1'b0, 6'd0}) begin n_fail++; $display("FAIL ds_short_frame: got %b/%b/%0d want 1/0/0", desync, running, level); end
   endtask

   task automatic test_full();
      push_words(24'h000500, 32, 0, 16);
      n_checks++; if ({level, s_ready} !== {6'd32, 1'b0}) begin n_fail++; $display("FAIL full_level: got %0d/%b want 32/0", level, s_ready); end
      s_valid = 1'b1; s_data = 24'h0005FF; s_sof = 1'b0;
      tick();
      s_valid = 1'b0;
      n_checks++; if (level !== 6'd32) begin n_fail++; $display("FAIL full_refuse: got %0d want 32", level); end
      pulse_fs();
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL full_run: got %b want 1", running); end
      display_en = 1'b1; s_valid = 1'b1; s_data = 24'h000600; s_sof = 1'b0;
      tick();
      n_checks++; if ({level, rgb} !== {6'd31, 24'h000500}) begin n_fail++; $display("FAIL full_pop_no_push: got %0d/%h want 31/000500", level, rgb); end
      s_data = 24'h000601; s_sof = 1'b1;
      tick();
      s_valid = 1'b0; s_sof = 1'b0;
      n_checks++; if ({level, rgb} !== {6'd31, 24'h000501}) begin n_fail++; $display("FAIL full_push_pop: got %0d/%h want 31/000501", level, rgb); end
      for (int k = 2; k < 33; k++) begin
         tick();
         n_checks++;
         if (k < 32) begin
            if ({rgb, desync} !== {24'h000500 + 24'(k), 1'b0}) begin n_fail++; $display("FAIL full_drain%0d: got %h/%b want %h/0", k, rgb, desync, 24'h000500 + 24'(k)); end
         end else begin
            if ({rgb, desync} !== {24'h000601, 1'b0}) begin n_fail++; $display("FAIL full_tail: got %h/%b want 000601/0", rgb, desync); end
         end
      end
      tick();
      display_en = 1'b0;
      n_checks++; if ({rgb, underflow, running} !== {ERR, 1'b1, 1'b0}) begin n_fail++; $display("FAIL full_uf2: got %h/%b/%b want %h/1/0", rgb, underflow, running, ERR); end
      push_words(24'h000700, 8, 0, -1);
      pulse_fs();
      for (int p = 0; p < 8; p++) begin
         display_en = 1'b1;
         tick();
         n_checks++; if (rgb !== 24'h000700 + 24'(p)) begin n_fail++; $display("FAIL full_px%0d: got %h want %h", p, rgb, 24'h000700 + 24'(p)); end
      end
      tick();
      display_en = 1'b0;
      n_checks++; if ({underflow, rgb} !== {1'b1, ERR}) begin n_fail++; $display("FAIL full_uf3: got %b/%h want 1/%h", underflow, rgb, ERR); end
`ifdef VGA_FEEDER_UNDERFLOW_CNT_EN
      n_checks++; if (underflow_cnt !== 16'd3) begin n_fail++; $display("FAIL uf_cnt: got %0d want 3", underflow_cnt); end
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_lock();
      test_steady();
      test_underflow();
      test_desync();
      test_full();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
